crca_check: RTL and testbench

CRCA_CHECK -- requirements
Module: crca_check

---
 rtl/crca_pkg.sv | 15 +
 rtl/crca_if.sv | 26 ++
 rtl/crca_lfsr_step.sv | 15 +
 rtl/crca_check.sv | 126 ++++++++++++
 tb/tb_crca_check.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/crca_pkg.sv
// Shared constants and state encoding for the CRC-16 checker and generator.
// Keeps the polynomial and preset in one place for both ends of the link.
package crca_pkg;

    localparam logic [15:0] CRCA_POLY = 16'h1021;
    localparam logic [15:0] CRCA_INIT = 16'hC6C6;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_DATA = 2'b01,
        S_CRC  = 2'b11,
        S_DONE = 2'b10
    } crca_state_e;

endpackage

// File: rtl/crca_if.sv
// Serial frame bus between a bit source and the CRC checker.
// The source drives the strobes, the checker returns status and CRC values.
interface crca_if;

    logic        start;
    logic        abort;
    logic        data;
    logic        valid;
    logic        busy;
    logic        done;
    logic        crc_ok;
    logic        crc_err;
    logic [15:0] crc_calc;
    logic [15:0] crc_rx;

    modport master (
        output start, abort, data, valid,
        input  busy, done, crc_ok, crc_err, crc_calc, crc_rx
    );

    modport slave (
        input  start, abort, data, valid,
        output busy, done, crc_ok, crc_err, crc_calc, crc_rx
    );

endinterface

// File: rtl/crca_lfsr_step.sv
// One-bit CRC-16 LFSR update, shared by the checker and the generator.
module crca_lfsr_step
    import crca_pkg::*;
(
    input  logic [15:0] r_i,
    input  logic        d_i,
    output logic [15:0] next_o
);

    logic fb;

    assign fb     = r_i[15] ^ d_i;
    assign next_o = {r_i[14:0], 1'b0} ^ (fb ? CRCA_POLY : 16'h0000);

endmodule

// File: rtl/crca_check.sv
// Serial CRC-16 frame checker: payload bits feed the LFSR, the trailing
// 16-bit field is captured MSB-first and compared in the DONE cycle.
module crca_check
    import crca_pkg::*;
#(
    parameter int          DATA_BITS = 32,
    parameter logic [15:0] CRC_INIT  = CRCA_INIT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic        data_i,
    input  logic        valid_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        crc_ok_o,
    output logic        crc_err_o,
    output logic [15:0] crc_calc_o,
    output logic [15:0] crc_rx_o
);

    // Counter also has to hold 15 for the CRC field on tiny payloads.
    localparam int CW0 = $clog2(DATA_BITS + 1);
    localparam int CW  = (CW0 < 4) ? 4 : CW0;

    crca_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [15:0]   rx_q, rx_d;
    logic          ok_q, ok_d;
    logic          err_q, err_d;
    logic [15:0]   lfsr_nxt;
    logic [15:0]   rx_shift;
    logic          cnt_zero;

    crca_lfsr_step u_step (
        .r_i    (lfsr_q),
        .d_i    (data_i),
        .next_o (lfsr_nxt)
    );

    assign rx_shift = {rx_q[14:0], data_i};
    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lfsr_d  = lfsr_q;
        rx_d    = rx_q;
        ok_d    = ok_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    lfsr_d  = CRC_INIT;
                    rx_d    = 16'h0000;
                    ok_d    = 1'b0;
                    err_d   = 1'b0;
                    cnt_d   = CW'(DATA_BITS - 1);
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (valid_i) begin
                    lfsr_d = lfsr_nxt;
                    if (cnt_zero) begin
                        cnt_d   = CW'(15);
                        state_d = S_CRC;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            S_CRC: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (valid_i) begin
                    rx_d = rx_shift;
                    if (cnt_zero) begin
                        // Verdict registers so it is visible during DONE.
                        ok_d    = (rx_shift == lfsr_q);
                        err_d   = (rx_shift != lfsr_q);
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            lfsr_q  <= CRC_INIT;
            rx_q    <= 16'h0000;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= lfsr_d;
            rx_q    <= rx_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
        end
    end

    assign busy_o     = (state_q == S_DATA) || (state_q == S_CRC);
    assign done_o     = (state_q == S_DONE);
    assign crc_ok_o   = ok_q;
    assign crc_err_o  = err_q;
    assign crc_calc_o = lfsr_q;
    assign crc_rx_o   = rx_q;

endmodule

// File: tb/tb_crca_check.sv
// Randomized self-checking bench for crca_check against a bitwise
// CRC-16 reference computed from the payload value.
module tb_crca_check;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [15:0] golden;

    always #5 clk = ~clk;

    crca_if bus ();

    crca_check #(
        .DATA_BITS (32),
        .CRC_INIT  (16'hC6C6)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (bus.start),
        .abort_i    (bus.abort),
        .data_i     (bus.data),
        .valid_i    (bus.valid),
        .busy_o     (bus.busy),
        .done_o     (bus.done),
        .crc_ok_o   (bus.crc_ok),
        .crc_err_o  (bus.crc_err),
        .crc_calc_o (bus.crc_calc),
        .crc_rx_o   (bus.crc_rx)
    );

    // Reference: MSB-first CRC-16/0x1021 over the payload value.
    function automatic logic [15:0] model_crc(input logic [31:0] p);
        int unsigned c;
        int unsigned top;
        int unsigned bitv;
        c = 32'hC6C6;
        for (int i = 31; i >= 0; i--) begin
            top  = (c >> 15) & 1;
            bitv = p[i] ? 1 : 0;
            c = (c << 1) & 32'hFFFF;
            if (top != bitv)
                c = c ^ 32'h1021;
        end
        return c[15:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send_bit(input logic b, input int gap, inout int busy_low);
        bus.valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            tick();
            if (bus.busy !== 1'b1)
                busy_low++;
        end
        bus.valid = 1'b1;
        bus.data  = b;
        tick();
        bus.valid = 1'b0;
        bus.data  = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] p, input logic [15:0] c,
                              input int maxgap, output int busy_low);
        int bl;
        bl = 0;
        do_start();
        for (int i = 31; i >= 0; i--)
            send_bit(p[i], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0, bl);
        for (int i = 15; i >= 0; i--)
            send_bit(c[i], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0, bl);
        busy_low = bl;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if ({bus.busy, bus.done, bus.crc_ok, bus.crc_err} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_flags got=%b want=0000",
                     {bus.busy, bus.done, bus.crc_ok, bus.crc_err});
        end
        total++;
        if (bus.crc_calc !== 16'hC6C6 || bus.crc_rx !== 16'h0000) begin
            bad++;
            $display("FAIL reset_crc calc=%h rx=%h want=c6c6/0000",
                     bus.crc_calc, bus.crc_rx);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_golden();
        int bl;
        golden = model_crc(32'hDEADBEEF);
        send_frame(32'hDEADBEEF, golden, 0, bl);
        total++;
        if (bus.done !== 1'b1 || bus.crc_ok !== 1'b1 || bus.crc_err !== 1'b0) begin
            bad++;
            $display("FAIL golden_result done=%b ok=%b err=%b want=1/1/0",
                     bus.done, bus.crc_ok, bus.crc_err);
        end
        total++;
        if (bus.crc_rx !== golden || bus.crc_calc !== golden) begin
            bad++;
            $display("FAIL golden_crc rx=%h calc=%h want=%h",
                     bus.crc_rx, bus.crc_calc, golden);
        end
        tick();
        total++;
        if (bus.done !== 1'b0 || bus.crc_ok !== 1'b1) begin
            bad++;
            $display("FAIL golden_pulse done=%b ok=%b want=0/1",
                     bus.done, bus.crc_ok);
        end
    endtask

    task automatic test_error();
        int bl;
        logic [31:0] p;
        p = 32'hDEADBEEF ^ 32'h0000_0020;
        send_frame(p, golden, 0, bl);
        total++;
        if (bus.done !== 1'b1 || bus.crc_ok !== 1'b0 || bus.crc_err !== 1'b1) begin
            bad++;
            $display("FAIL error_result done=%b ok=%b err=%b want=1/0/1",
                     bus.done, bus.crc_ok, bus.crc_err);
        end
        total++;
        if (bus.crc_rx !== golden || bus.crc_calc !== model_crc(p)) begin
            bad++;
            $display("FAIL error_crc rx=%h calc=%h want=%h/%h",
                     bus.crc_rx, bus.crc_calc, golden, model_crc(p));
        end
        tick();
    endtask

    task automatic test_stall();
        int bl;
        send_frame(32'hDEADBEEF, golden, 7, bl);
        total++;
        if (bl !== 0) begin
            bad++;
            $display("FAIL stall_busy low_cycles=%0d want=0", bl);
        end
        total++;
        if (bus.done !== 1'b1 || bus.crc_ok !== 1'b1 || bus.crc_calc !== golden) begin
            bad++;
            $display("FAIL stall_result done=%b ok=%b calc=%h want=1/1/%h",
                     bus.done, bus.crc_ok, bus.crc_calc, golden);
        end
        tick();
    endtask

    task automatic test_abort();
        int bl;
        int seen;
        logic [31:0] p;
        p = 32'hDEADBEEF;
        bl = 0;
        do_start();
        for (int i = 31; i > 21; i--)
            send_bit(p[i], 0, bl);
        bus.valid = 1'b1;
        bus.abort = 1'b1;
        bus.data  = p[21];
        tick();
        bus.valid = 1'b0;
        bus.abort = 1'b0;
        total++;
        if ({bus.busy, bus.done, bus.crc_ok, bus.crc_err} !== 4'b0000) begin
            bad++;
            $display("FAIL abort_idle got=%b want=0000",
                     {bus.busy, bus.done, bus.crc_ok, bus.crc_err});
        end
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (bus.done === 1'b1)
                seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL abort_nodone pulses=%0d want=0", seen);
        end
        send_frame(32'hDEADBEEF, golden, 0, bl);
        total++;
        if (bus.done !== 1'b1 || bus.crc_ok !== 1'b1) begin
            bad++;
            $display("FAIL abort_refresh done=%b ok=%b want=1/1",
                     bus.done, bus.crc_ok);
        end
        tick();
    endtask

    task automatic test_reset_restart();
        int bl;
        logic [31:0] p;
        p = 32'hDEADBEEF;
        bl = 0;
        do_start();
        for (int i = 31; i >= 0; i--)
            send_bit(p[i], 0, bl);
        for (int i = 15; i > 10; i--)
            send_bit(golden[i], 0, bl);
        rst       = 1'b1;
        bus.valid = 1'b1;
        bus.data  = golden[10];
        tick();
        rst       = 1'b0;
        bus.valid = 1'b0;
        total++;
        if ({bus.busy, bus.done, bus.crc_ok, bus.crc_err} !== 4'b0000
            || bus.crc_calc !== 16'hC6C6 || bus.crc_rx !== 16'h0000) begin
            bad++;
            $display("FAIL midreset flags=%b calc=%h rx=%h",
                     {bus.busy, bus.done, bus.crc_ok, bus.crc_err},
                     bus.crc_calc, bus.crc_rx);
        end
        send_frame(32'hDEADBEEF, golden, 0, bl);
        bus.start = 1'b1;
        tick();
        total++;
        if (bus.busy !== 1'b0 || bus.crc_ok !== 1'b1) begin
            bad++;
            $display("FAIL done_start_ignored busy=%b ok=%b want=0/1",
                     bus.busy, bus.crc_ok);
        end
        tick();
        bus.start = 1'b0;
        total++;
        if (bus.busy !== 1'b1 || bus.crc_ok !== 1'b0 || bus.crc_calc !== 16'hC6C6) begin
            bad++;
            $display("FAIL restart busy=%b ok=%b calc=%h want=1/0/c6c6",
                     bus.busy, bus.crc_ok, bus.crc_calc);
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
    endtask

    task automatic test_random();
        int bl;
        logic [31:0] p;
        logic [15:0] c;
        logic [15:0] m;
        logic corrupt;
        for (int n = 0; n < 10; n++) begin
            p = $urandom;
            m = model_crc(p);
            corrupt = ($urandom_range(1, 0) == 1);
            c = corrupt ? (m ^ 16'(1 << $urandom_range(15, 0))) : m;
            send_frame(p, c, 3, bl);
            total++;
            if (bus.done !== 1'b1 || bus.crc_ok !== !corrupt
                || bus.crc_err !== corrupt) begin
                bad++;
                $display("FAIL rand_result n=%0d done=%b ok=%b err=%b corrupt=%b",
                         n, bus.done, bus.crc_ok, bus.crc_err, corrupt);
            end
            total++;
            if (bus.crc_calc !== m || bus.crc_rx !== c || bl !== 0) begin
                bad++;
                $display("FAIL rand_crc n=%0d calc=%h rx=%h lowbusy=%0d want=%h/%h/0",
                         n, bus.crc_calc, bus.crc_rx, bl, m, c);
            end
            tick();
            bus.valid = 1'b1;
            bus.data  = ($urandom_range(1, 0) == 1);
            tick();
            tick();
            bus.valid = 1'b0;
            total++;
            if (bus.crc_calc !== m || bus.crc_rx !== c || bus.busy !== 1'b0) begin
                bad++;
                $display("FAIL idle_valid n=%0d calc=%h rx=%h busy=%b want=%h/%h/0",
                         n, bus.crc_calc, bus.crc_rx, bus.busy, m, c);
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.data  = 1'b0;
        bus.valid = 1'b0;
        golden    = 16'h0000;
        test_reset();
        test_golden();
        test_error();
        test_stall();
        test_abort();
        test_reset_restart();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
